// File: rtl/mmwave_chirp_scheduler_if.sv
// Configuration and timing-strobe bundle of the chirp scheduler.
// master drives configuration and observes strobes; slave is the scheduler side.
interface mmwave_chirp_scheduler_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   cfg_sys_en_i;
  logic                   cfg_vco_enable_i;
  logic [15:0]            cfg_chirp_freq_psc_i;
  logic [4:0]             cfg_chirp_num_i;
  logic [31:0]            cfg_period_psc_i;
  logic [31:0]            cfg_ad_samplerate_psc_i;
  logic                   chirp_start_o;
  logic                   chirp_active_o;
  logic [4:0]             chirp_idx_o;
  logic                   ad_sample_tick_o;
  logic                   frame_done_o;
  logic [FRAME_CNT_W-1:0] frame_cnt_o;
  logic                   busy_o;
  logic                   cfg_err_o;

  modport master (
    output cfg_sys_en_i, cfg_vco_enable_i, cfg_chirp_freq_psc_i,
           cfg_chirp_num_i, cfg_period_psc_i, cfg_ad_samplerate_psc_i,
    input  chirp_start_o, chirp_active_o, chirp_idx_o, ad_sample_tick_o,
           frame_done_o, frame_cnt_o, busy_o, cfg_err_o
  );

  modport slave (
    input  cfg_sys_en_i, cfg_vco_enable_i, cfg_chirp_freq_psc_i,
           cfg_chirp_num_i, cfg_period_psc_i, cfg_ad_samplerate_psc_i,
    output chirp_start_o, chirp_active_o, chirp_idx_o, ad_sample_tick_o,
           frame_done_o, frame_cnt_o, busy_o, cfg_err_o
  );
endinterface

// File: rtl/mmwave_chirp_scheduler.sv
// Frame/chirp/ADC-tick sequencer for an FMCW radar front end; all outputs registered,
// first chirp one cycle after the start condition; no backpressure (free-running timer).
module mmwave_chirp_scheduler #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  mmwave_chirp_scheduler_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, CHIRP, GAP} state_t;

  state_t                 state, nxt_state;
  logic [31:0]            fc, nxt_fc;
  logic [15:0]            co, nxt_co;
  logic [4:0]             idx, nxt_idx;
  logic [31:0]            scnt, nxt_scnt;
  logic [4:0]             num, nxt_num;
  logic [15:0]            len, nxt_len;
  logic [31:0]            spl, nxt_spl;
  logic [31:0]            last, nxt_last;
  logic [FRAME_CNT_W-1:0] frame_cnt, nxt_frame_cnt;
  logic                   err, nxt_err;

  logic                   chirp_start, chirp_active, sample_tick, frame_done, busy;
  logic                   nxt_start, nxt_active, nxt_tick, nxt_done, nxt_busy;

  logic [20:0]            in_nl;
  logic [31:0]            in_nl_ext;
  logic [31:0]            in_last;
  logic                   in_short;
  logic                   cfg_ok;
  logic                   start_ok;
  logic                   sample_hit;
  logic                   launch;

  // Frame geometry derived directly from the live configuration, used only at a latch point.
  assign in_nl     = {16'd0, bus.cfg_chirp_num_i} * {5'd0, bus.cfg_chirp_freq_psc_i};
  assign in_nl_ext = {11'd0, in_nl};
  assign in_last   = ((bus.cfg_period_psc_i > in_nl_ext) ? bus.cfg_period_psc_i : in_nl_ext) - 32'd1;
  assign in_short  = bus.cfg_period_psc_i < in_nl_ext;
  assign cfg_ok    = (bus.cfg_chirp_num_i != 5'd0) && (bus.cfg_chirp_freq_psc_i != 16'd0);
  assign start_ok  = bus.cfg_sys_en_i && bus.cfg_vco_enable_i && cfg_ok;
  assign sample_hit = (spl != 32'd0) && (scnt == spl - 32'd1);

  always_comb begin
    nxt_state     = state;
    nxt_fc        = fc;
    nxt_co        = co;
    nxt_idx       = idx;
    nxt_scnt      = scnt;
    nxt_num       = num;
    nxt_len       = len;
    nxt_spl       = spl;
    nxt_last      = last;
    nxt_err       = err;
    nxt_frame_cnt = frame_cnt;
    launch        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.cfg_sys_en_i && bus.cfg_vco_enable_i) begin
          if (cfg_ok) launch = 1'b1;
          else        nxt_err = 1'b1;
        end
      end
      default: begin
        if (!bus.cfg_sys_en_i) begin
          nxt_state = IDLE;
        end else if (fc == last) begin
          if (start_ok) launch = 1'b1;
          else          nxt_state = IDLE;
        end else begin
          nxt_fc = fc + 32'd1;
          if (state == CHIRP) begin
            if (co == len - 16'd1) begin
              if (idx == num - 5'd1) begin
                nxt_state = GAP;
              end else begin
                nxt_co   = 16'd0;
                nxt_idx  = idx + 5'd1;
                nxt_scnt = 32'd0;
              end
            end else begin
              nxt_co   = co + 16'd1;
              nxt_scnt = sample_hit ? 32'd0 : scnt + 32'd1;
            end
          end
        end
      end
    endcase

    // A frame start relatches the whole configuration, whether from IDLE or back-to-back.
    if (launch) begin
      nxt_state = CHIRP;
      nxt_fc    = 32'd0;
      nxt_co    = 16'd0;
      nxt_idx   = 5'd0;
      nxt_scnt  = 32'd0;
      nxt_num   = bus.cfg_chirp_num_i;
      nxt_len   = bus.cfg_chirp_freq_psc_i;
      nxt_spl   = bus.cfg_ad_samplerate_psc_i;
      nxt_last  = in_last;
      if (in_short) nxt_err = 1'b1;
    end

    if (nxt_state == IDLE) begin
      nxt_fc   = 32'd0;
      nxt_co   = 16'd0;
      nxt_idx  = 5'd0;
      nxt_scnt = 32'd0;
    end

    if (!bus.cfg_sys_en_i) nxt_err = 1'b0;

    nxt_active = (nxt_state == CHIRP);
    nxt_start  = nxt_active && (nxt_co == 16'd0);
    nxt_tick   = nxt_active && (nxt_spl != 32'd0) && (nxt_scnt == nxt_spl - 32'd1);
    nxt_busy   = (nxt_state != IDLE);
    nxt_done   = nxt_busy && (nxt_fc == nxt_last);
    if (nxt_done) nxt_frame_cnt = frame_cnt + FRAME_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fc           <= 32'd0;
      co           <= 16'd0;
      idx          <= 5'd0;
      scnt         <= 32'd0;
      num          <= 5'd0;
      len          <= 16'd0;
      spl          <= 32'd0;
      last         <= 32'd0;
      err          <= 1'b0;
      frame_cnt    <= '0;
      chirp_start  <= 1'b0;
      chirp_active <= 1'b0;
      sample_tick  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt_state;
      fc           <= nxt_fc;
      co           <= nxt_co;
      idx          <= nxt_idx;
      scnt         <= nxt_scnt;
      num          <= nxt_num;
      len          <= nxt_len;
      spl          <= nxt_spl;
      last         <= nxt_last;
      err          <= nxt_err;
      frame_cnt    <= nxt_frame_cnt;
      chirp_start  <= nxt_start;
      chirp_active <= nxt_active;
      sample_tick  <= nxt_tick;
      frame_done   <= nxt_done;
      busy         <= nxt_busy;
    end
  end

  assign bus.chirp_start_o    = chirp_start;
  assign bus.chirp_active_o   = chirp_active;
  assign bus.chirp_idx_o      = idx;
  assign bus.ad_sample_tick_o = sample_tick;
  assign bus.frame_done_o     = frame_done;
  assign bus.frame_cnt_o      = frame_cnt;
  assign bus.busy_o           = busy;
  assign bus.cfg_err_o        = err;

endmodule

// File: tb/tb_mmwave_chirp_scheduler.sv
// Directed bench for the chirp scheduler: per-cycle strobes recorded into bit masks
// indexed by frame cycle and compared against hand-derived masks.
module tb_mmwave_chirp_scheduler;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   err_cnt;

  logic [127:0] rec_start, rec_active, rec_tick, rec_done, rec_busy;
  int           rec_idx [0:127];
  int           rec_fcnt[0:127];

  mmwave_chirp_scheduler_if #(.FRAME_CNT_W(16)) intf();

  mmwave_chirp_scheduler #(.FRAME_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bit_at(input int k);
    logic [127:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] all_outs();
    return {96'd0, intf.chirp_start_o, intf.chirp_active_o, intf.ad_sample_tick_o,
            intf.frame_done_o, intf.busy_o, intf.cfg_err_o, intf.chirp_idx_o, intf.frame_cnt_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    intf.cfg_sys_en_i            = 1'b0;
    intf.cfg_vco_enable_i        = 1'b0;
    intf.cfg_chirp_freq_psc_i    = 16'd0;
    intf.cfg_chirp_num_i         = 5'd0;
    intf.cfg_period_psc_i        = 32'd0;
    intf.cfg_ad_samplerate_psc_i = 32'd0;
    step();
    step();
    check_val("reset_outputs", all_outs(), 128'd0);
    rst = 1'b0;
  endtask

  task automatic configure(input int n, input int l, input int p, input int s);
    intf.cfg_chirp_num_i         = 5'(n);
    intf.cfg_chirp_freq_psc_i    = 16'(l);
    intf.cfg_period_psc_i        = 32'(p);
    intf.cfg_ad_samplerate_psc_i = 32'(s);
    intf.cfg_sys_en_i            = 1'b1;
    intf.cfg_vco_enable_i        = 1'b1;
  endtask

  // Record ncyc cycles starting at the current cycle; kind 1/2/3 drops sys_en / drops vco / sets L=6 at chg_at.
  task automatic run_rec(input int ncyc, input int chg_at, input int kind);
    rec_start = '0; rec_active = '0; rec_tick = '0; rec_done = '0; rec_busy = '0;
    for (int i = 0; i < ncyc; i++) begin
      rec_start[i]  = intf.chirp_start_o;
      rec_active[i] = intf.chirp_active_o;
      rec_tick[i]   = intf.ad_sample_tick_o;
      rec_done[i]   = intf.frame_done_o;
      rec_busy[i]   = intf.busy_o;
      rec_idx[i]    = int'(intf.chirp_idx_o);
      rec_fcnt[i]   = int'(intf.frame_cnt_o);
      if (i == chg_at) begin
        case (kind)
          1: intf.cfg_sys_en_i = 1'b0;
          2: intf.cfg_vco_enable_i = 1'b0;
          3: intf.cfg_chirp_freq_psc_i = 16'd6;
          default: ;
        endcase
      end
      step();
    end
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;

    // Nominal frame: N=3 L=10 P=50 S=4, observed over fc 0..50.
    do_reset();
    configure(3, 10, 50, 4);
    step();
    run_rec(51, -1, 0);
    check_val("s1_start", rec_start, bit_at(0) | bit_at(10) | bit_at(20) | bit_at(50));
    check_val("s1_active", rec_active, span(0, 29) | bit_at(50));
    check_val("s1_tick", rec_tick, bit_at(3) | bit_at(7) | bit_at(13) | bit_at(17) | bit_at(23) | bit_at(27));
    check_val("s1_done", rec_done, bit_at(49));
    check_val("s1_busy", rec_busy, span(0, 50));
    check_val("s1_idx25", 128'(rec_idx[25]), 128'd2);
    check_val("s1_idx50", 128'(rec_idx[50]), 128'd0);
    check_val("s1_fcnt48", 128'(rec_fcnt[48]), 128'd0);
    check_val("s1_fcnt49", 128'(rec_fcnt[49]), 128'd1);
    check_val("s1_err", 128'(intf.cfg_err_o), 128'd0);

    // P shorter than N*L: no gap, error flagged, back-to-back frames.
    do_reset();
    configure(4, 10, 20, 0);
    step();
    check_val("s2_err_fc0", 128'(intf.cfg_err_o), 128'd1);
    run_rec(41, -1, 0);
    check_val("s2_start", rec_start, bit_at(0) | bit_at(10) | bit_at(20) | bit_at(30) | bit_at(40));
    check_val("s2_active", rec_active, span(0, 40));
    check_val("s2_tick_none", rec_tick, 128'd0);
    check_val("s2_done", rec_done, bit_at(39));

    // System enable dropped at fc=15.
    do_reset();
    configure(3, 10, 50, 4);
    step();
    run_rec(20, 15, 1);
    check_val("s3_active", rec_active, span(0, 15));
    check_val("s3_busy", rec_busy, span(0, 15));
    check_val("s3_done_none", rec_done, 128'd0);
    check_val("s3_tick", rec_tick, bit_at(3) | bit_at(7) | bit_at(13));
    check_val("s3_outs_idle", all_outs(), 128'd0);

    // VCO enable dropped at fc=5: frame completes then idles.
    do_reset();
    configure(3, 10, 50, 4);
    step();
    run_rec(52, 5, 2);
    check_val("s4_start", rec_start, bit_at(0) | bit_at(10) | bit_at(20));
    check_val("s4_done", rec_done, bit_at(49));
    check_val("s4_busy", rec_busy, span(0, 49));
    check_val("s4_fcnt51", 128'(rec_fcnt[51]), 128'd1);

    // L changed to 6 mid-frame: takes effect on the following frame only.
    do_reset();
    configure(3, 10, 50, 4);
    step();
    run_rec(70, 5, 3);
    check_val("s5_start", rec_start, bit_at(0) | bit_at(10) | bit_at(20) | bit_at(50) | bit_at(56) | bit_at(62));
    check_val("s5_active", rec_active, span(0, 29) | span(50, 67));
    check_val("s5_tick", rec_tick, bit_at(3) | bit_at(7) | bit_at(13) | bit_at(17) | bit_at(23) | bit_at(27)
                                   | bit_at(53) | bit_at(59) | bit_at(65));

    // Minimal geometry: L=1, S=1, P=0 -> every cycle a chirp start and tick, frame of 2.
    do_reset();
    configure(2, 1, 0, 1);
    step();
    run_rec(4, -1, 0);
    check_val("s6_start", rec_start, span(0, 3));
    check_val("s6_tick", rec_tick, span(0, 3));
    check_val("s6_done", rec_done, bit_at(1) | bit_at(3));
    check_val("s6_err", 128'(intf.cfg_err_o), 128'd1);

    // N=0 with enables high: stays idle with error; sys_en low clears it.
    do_reset();
    configure(0, 10, 50, 4);
    step(); step(); step();
    check_val("s7_busy", 128'(intf.busy_o), 128'd0);
    check_val("s7_err", 128'(intf.cfg_err_o), 128'd1);
    intf.cfg_sys_en_i = 1'b0;
    step();
    check_val("s7_err_clr", 128'(intf.cfg_err_o), 128'd0);

    // Asynchronous reset mid-chirp, then a fresh start is required.
    configure(3, 10, 10, 4);
    step();
    run_rec(15, -1, 0);
    check_val("s8_pre_idx", 128'(intf.chirp_idx_o), 128'd1);
    check_val("s8_pre_err", 128'(intf.cfg_err_o), 128'd1);
    #3;
    rst = 1'b1;
    #1;
    check_val("s8_async_rst", all_outs(), 128'd0);
    intf.cfg_vco_enable_i = 1'b0;
    #2;
    rst = 1'b0;
    step(); step();
    check_val("s8_post_idle", 128'(intf.busy_o), 128'd0);
    intf.cfg_vco_enable_i = 1'b1;
    step();
    check_val("s8_restart", {126'd0, intf.busy_o, intf.chirp_start_o}, 128'd3);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
